// File: rtl/cpu_mc.sv
// cpu_mc: parametrised multi-cycle core with host program load, run/halt FSM and handshaked I/O.
// Latency: 2 cycles per ALU/LDI/ST/branch instruction, 3 for LD; IN/OUT add handshake wait cycles.
// Backpressure: IN stalls in WAIT_IN until in_valid; OUT holds out_valid/out_data until out_ready.
module cpu_mc #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int IMEM_AW = 6,
  parameter int RAM_AW  = 8,
  localparam int INST_W = 4 + 3 * REG_AW,
  localparam int IMM_W  = 2 * REG_AW
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load_we,
  input  logic [IMEM_AW-1:0] load_addr,
  input  logic [INST_W-1:0]  load_inst,
  input  logic               start,
  output logic               halted,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic               ram_we,
  output logic [DATA_W-1:0]  ram_d,
  input  logic [DATA_W-1:0]  ram_q
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WAIT_IN, S_WAIT_OUT, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0,  OP_ADD = 4'd1,  OP_SUB  = 4'd2,  OP_AND = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4,  OP_XOR = 4'd5,  OP_SHL  = 4'd6,  OP_SHR = 4'd7;
  localparam logic [3:0] OP_LDI  = 4'd8,  OP_LD  = 4'd9,  OP_ST   = 4'd10, OP_IN  = 4'd11;
  localparam logic [3:0] OP_OUT  = 4'd12, OP_BEQZ = 4'd13, OP_JMP = 4'd14, OP_HALT = 4'd15;

  localparam logic [DATA_W-1:0] SH_LIM = DATA_W'(DATA_W);

  state_t              state;
  logic [IMEM_AW-1:0]  pc;
  logic [INST_W-1:0]   ir;
  logic [DATA_W-1:0]   regs [2**REG_AW];
  logic [INST_W-1:0]   imem [2**IMEM_AW];

  logic [3:0]          op;
  logic [REG_AW-1:0]   rd, rs0, rs1;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   a, b, alu;
  logic [3:0]          f_op;

  assign op   = ir[INST_W-1 -: 4];
  assign rd   = ir[3*REG_AW-1 -: REG_AW];
  assign rs0  = ir[2*REG_AW-1 -: REG_AW];
  assign rs1  = ir[REG_AW-1:0];
  assign imm  = ir[IMM_W-1:0];
  assign a    = regs[rs0];
  assign b    = regs[rs1];
  // opcode of the word being fetched, so RAM strobes can be registered ahead of EXEC
  assign f_op = imem[pc][INST_W-1 -: 4];

  // ALU result for the instruction held in ir; oversized shift amounts flush to zero
  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_SHL:  alu = (b >= SH_LIM) ? '0 : (a << b);
      OP_SHR:  alu = (b >= SH_LIM) ? '0 : (a >> b);
      default: alu = '0;
    endcase
  end

  // run/halt FSM with register writeback, host loading and registered bus/handshake outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      halted    <= 1'b1;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_d     <= '0;
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
      for (int i = 0; i < 2**IMEM_AW; i++) imem[i] <= '0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          // a same-cycle load and start both take effect; FETCH then sees the new word
          if (load_we) imem[load_addr] <= load_inst;
          if (start) begin
            pc     <= '0;
            halted <= 1'b0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir    <= imem[pc];
          state <= S_EXEC;
          // RAM address/data/strobe are launched here so they are valid throughout EXEC
          if (f_op == OP_LD || f_op == OP_ST) begin
            ram_addr <= RAM_AW'(regs[imem[pc][2*REG_AW-1 -: REG_AW]]);
            ram_d    <= regs[imem[pc][REG_AW-1:0]];
            ram_we   <= (f_op == OP_ST);
          end
        end
        S_EXEC: begin
          pc    <= pc + 1'b1;
          state <= S_FETCH;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: regs[rd] <= alu;
            OP_LDI:  regs[rd] <= DATA_W'(imm);
            OP_LD:   state <= S_MEM;
            OP_IN: begin
              in_ready <= 1'b1;
              state    <= S_WAIT_IN;
            end
            OP_OUT: begin
              out_valid <= 1'b1;
              out_data  <= a;
              state     <= S_WAIT_OUT;
            end
            OP_BEQZ: if (regs[rd] == '0) pc <= IMEM_AW'(imm);
            OP_JMP:  pc <= IMEM_AW'(imm);
            OP_HALT: begin
              pc     <= pc;
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          regs[rd] <= ram_q;
          state    <= S_FETCH;
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            regs[rd] <= in_data;
            in_ready <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_WAIT_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
